// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution frame sequencer.
// Op codes match the convolutor3x3 engine encoding.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FEED,
    CLR,
    DONE
  } state_e;

  localparam logic [1:0] OP_CONV = 2'd0;
  localparam logic [1:0] OP_POOL = 2'd1;

  localparam int MAX_W = 128;
  localparam int MAX_H = 128;
  localparam int PIX_W = 8;
  localparam int ACC_W = 32;

endpackage

// File: rtl/conv_raster_counter.sv
// Raster position counter: linear pixel count plus a column counter
// that wraps at the row width, so no divider is needed for cnt mod W.
module conv_raster_counter #(
  parameter int CW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic [7:0]    width,
  input  logic [CW-1:0] last_cnt,
  output logic [CW-1:0] cnt,
  output logic [7:0]    col,
  output logic          col_first,
  output logic          col_second,
  output logic          at_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      col <= '0;
    end else if (clear) begin
      cnt <= '0;
      col <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
      col <= (col == width - 8'd1) ? 8'd0 : col + 8'd1;
    end
  end

  assign col_first  = col == 8'd0;
  assign col_second = col == 8'd1;
  assign at_last    = cnt == last_cnt;

endmodule

// File: rtl/conv3x3_sequencer.sv
// Frame controller for one convolutor3x3 engine: streams the image plus
// W+2 flush pixels, writes N results in order, then resets the engine.
module conv3x3_sequencer #(
  parameter int MAX_W  = conv_pkg::MAX_W,
  parameter int MAX_H  = conv_pkg::MAX_H,
  parameter int PIX_W  = conv_pkg::PIX_W,
  parameter int ACC_W  = conv_pkg::ACC_W,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_width,
  input  logic [7:0]        cfg_height,
  input  logic [1:0]        cfg_op,
  input  logic              cfg_relu,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  conv_pixel_in,
  output logic              conv_paddingl,
  output logic              conv_paddingr,
  output logic [1:0]        conv_op,
  output logic [7:0]        conv_width,
  output logic              conv_relu,
  output logic              conv_rst_n,
  input  logic [ACC_W-1:0]  conv_pixel_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data
);
  import conv_pkg::*;

  localparam int CW = ADDR_W + 1;

  state_e state, state_n;

  logic [7:0]    w_q, h_q;
  logic [1:0]    op_q;
  logic          relu_q;
  logic          abort_q;
  logic          clr_q;
  logic [CW-1:0] cnt, n_pix, last_cnt, nxt;
  logic [7:0]    col;
  logic          col_first, col_second, at_last;
  logic          cfg_ok, req, feed, rd_ok, wr_go;

  assign cfg_ok = cfg_width >= 8'd2
               && int'(cfg_width) <= MAX_W
               && cfg_height != 8'd0
               && int'(cfg_height) <= MAX_H;
  assign req      = start & ~abort;
  assign n_pix    = CW'(w_q) * CW'(h_q);
  assign last_cnt = n_pix + CW'(w_q) + CW'(1);
  assign nxt      = cnt + CW'(1);
  assign feed     = state == FEED;
  assign rd_ok    = feed && nxt < n_pix;
  // Engine output lags its input by W+2 pixels.
  assign wr_go    = feed && !abort
                 && cnt >= CW'(w_q) + CW'(2);

  conv_raster_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == PRIME),
    .en         (feed),
    .width      (w_q),
    .last_cnt   (last_cnt),
    .cnt        (cnt),
    .col        (col),
    .col_first  (col_first),
    .col_second (col_second),
    .at_last    (at_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    rd_en         = 1'b0;
    rd_addr       = '0;
    conv_pixel_in = '0;
    conv_paddingl = 1'b0;
    conv_paddingr = 1'b0;
    unique case (state)
      IDLE:  if (req && cfg_ok) state_n = PRIME;
      PRIME: state_n = abort ? CLR : FEED;
      FEED:  if (abort || at_last) state_n = CLR;
      CLR:   state_n = abort_q ? IDLE : DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state == PRIME) rd_en = 1'b1;
    if (rd_ok) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(nxt);
    end
    if (feed) begin
      conv_paddingl = col_first;
      conv_paddingr = col_second;
      if (cnt < n_pix) conv_pixel_in = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      clr_q   <= 1'b0;
      abort_q <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      w_q     <= '0;
      h_q     <= '0;
      op_q    <= '0;
      relu_q  <= 1'b0;
    end else begin
      if (state == IDLE && req && cfg_ok) begin
        w_q    <= cfg_width;
        h_q    <= cfg_height;
        op_q   <= cfg_op;
        relu_q <= cfg_relu;
      end
      err   <= state == IDLE && req && !cfg_ok;
      busy  <= state_n inside {PRIME, FEED, CLR};
      done  <= state_n == DONE;
      clr_q <= state_n == CLR;
      if (state_n == CLR) abort_q <= abort;
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= ADDR_W'(cnt - CW'(w_q) - CW'(2));
        wr_data <= conv_pixel_out;
      end
    end
  end

  assign conv_op    = op_q;
  assign conv_width = w_q;
  assign conv_relu  = relu_q;
  assign conv_rst_n = rst_n & ~clr_q;

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Bench for conv3x3_sequencer with a behavioural 3x3 engine,
// image buffer and result scoreboard.
module tb_conv3x3_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  cfg_height = '0;
  logic [1:0]  cfg_op = '0;
  logic        cfg_relu = 1'b0;
  logic        busy, done, err, rd_en;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic [7:0]  conv_pixel_in;
  logic        conv_paddingl, conv_paddingr;
  logic [1:0]  conv_op;
  logic [7:0]  conv_width;
  logic        conv_relu, conv_rst_n;
  logic [31:0] conv_pixel_out = '0;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;

  conv3x3_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_op         (cfg_op),
    .cfg_relu       (cfg_relu),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .conv_pixel_in  (conv_pixel_in),
    .conv_paddingl  (conv_paddingl),
    .conv_paddingr  (conv_paddingr),
    .conv_op        (conv_op),
    .conv_width     (conv_width),
    .conv_relu      (conv_relu),
    .conv_rst_n     (conv_rst_n),
    .conv_pixel_out (conv_pixel_out),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int img[16384];
  int stream[16700];
  int res[16384];
  int fw = 4, fh = 4;
  bit frelu = 1'b0;
  int prev_w = 0;
  int pos = 0;
  bit started = 1'b0;
  int exp_idx = 0, last_writes = 0;
  int total_writes = 0, done_cnt = 0;
  int wt[9] = '{0, 1, 0, -1, 39, -1, 0, 2, 0};
  int gimg[16] = '{14, 1, 0, 100, 0, -1, 0, -100,
                   0, 0, 0, 0, 1, 2, 0, 1};
  int gexp[16] = '{544, 22, 0, 3699, 14, 0, 100, 0,
                   1, 2, 0, 0, 36, 76, 0, 38};

  typedef struct {
    int w;
    int h;
    bit relu;
    bit exp_err;
    int exp_lat;
    int exp_wr;
  } vec_t;

  vec_t vt[11];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Zero-padded 3x3 convolution, bias -1, from the image or the
  // pixel stream the engine actually received.
  function automatic int conv_at(int k, bit from_stream, bit relu);
    int r, c, rr, cc, s, v;
    r = k / fw;
    c = k % fw;
    s = -1;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr < 0 || cc < 0 || cc >= fw) v = 0;
        else if (from_stream) v = stream[rr*fw+cc];
        else if (rr >= fh) v = 0;
        else v = img[rr*fw+cc];
        s += wt[(dr+1)*3 + dc + 1] * v;
      end
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      chk("rd_range", int'(rd_addr) < fw*fh, 1);
      rd_data <= 8'(img[rd_addr]);
    end
    if (wr_en) begin
      chk("wr_addr", int'(wr_addr), exp_idx);
      chk("wr_data", int'($signed(wr_data)),
          conv_at(int'(wr_addr), 1'b0, frelu));
      res[wr_addr] = int'($signed(wr_data));
      exp_idx++;
      total_writes++;
    end
    if (done) done_cnt++;
    if (!conv_rst_n) begin
      started = 1'b0;
      pos = 0;
      last_writes = exp_idx;
      exp_idx = 0;
      conv_pixel_out <= '0;
    end else begin
      if (!started && conv_paddingl) started = 1'b1;
      if (started && pos < fw*fh + fw + 2) begin
        chk("padl", int'(conv_paddingl), int'(pos % fw == 0));
        chk("padr", int'(conv_paddingr), int'(pos % fw == 1));
        chk("pix_in", int'($signed(conv_pixel_in)),
            pos < fw*fh ? img[pos] : 0);
        stream[pos] = int'($signed(conv_pixel_in));
        pos++;
        if (pos >= fw + 2 && pos - fw - 2 < fw*fh)
          conv_pixel_out <= 32'(conv_at(pos - fw - 2, 1'b1, conv_relu));
        else
          conv_pixel_out <= '0;
      end
    end
  end

  task automatic fill_rand(int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      img[i] = int'($signed(b));
    end
  endtask

  task automatic load_golden();
    for (int i = 0; i < 16; i++) begin
      img[i] = gimg[i];
      res[i] = -12345;
    end
  endtask

  task automatic check_golden(string tag);
    for (int i = 0; i < 16; i++) chk(tag, res[i], gexp[i]);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_pix", int'(conv_pixel_in), 0);
    chk("rst_padl", conv_paddingl, 0);
    chk("rst_padr", conv_paddingr, 0);
    chk("rst_conv_rst", conv_rst_n, 0);
    chk("rst_width", int'(conv_width), 0);
    chk("rst_op", int'(conv_op), 0);
    chk("rst_relu", conv_relu, 0);
  endtask

  task automatic wait_done(output int cyc, output int clr);
    cyc = 0;
    clr = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!conv_rst_n) clr++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic issue_start(int w, int h, bit relu, logic [1:0] op);
    @(negedge clk);
    cfg_width  = 8'(w);
    cfg_height = 8'(h);
    cfg_relu   = relu;
    cfg_op     = op;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(int w, int h, bit relu, logic [1:0] op,
                           bit exp_err, int exp_lat, int exp_wr);
    int cyc, clr;
    if (!exp_err) begin
      fw = w;
      fh = h;
      frelu = relu;
    end
    issue_start(w, h, relu, op);
    if (exp_err) begin
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_idle", busy, 0);
      chk("cfg_kept", int'(conv_width), prev_w);
    end else begin
      chk("prime_busy", busy, 1);
      chk("prime_err", err, 0);
      chk("prime_rd", int'(rd_en && rd_addr == 0), 1);
      chk("cfg_w", int'(conv_width), w);
      chk("cfg_op", int'(conv_op), int'(op));
      chk("cfg_relu", conv_relu, relu);
      wait_done(cyc, clr);
      chk("done_lat", cyc, exp_lat);
      chk("done_busy", busy, 0);
      chk("clr_cycles", clr, 1);
      chk("writes", last_writes, exp_wr);
      @(negedge clk);
      chk("done_pulse", done, 0);
      prev_w = w;
    end
  endtask

  initial begin
    int cyc, clr, c0, d0, w, h;
    bit r;

    vt[0]  = '{1,   4,   1'b0, 1'b1, 0,   0};
    vt[1]  = '{129, 4,   1'b0, 1'b1, 0,   0};
    vt[2]  = '{4,   0,   1'b0, 1'b1, 0,   0};
    vt[3]  = '{4,   129, 1'b0, 1'b1, 0,   0};
    vt[4]  = '{0,   0,   1'b1, 1'b1, 0,   0};
    vt[5]  = '{2,   1,   1'b1, 1'b0, 8,   2};
    vt[6]  = '{4,   4,   1'b0, 1'b0, 24,  16};
    vt[7]  = '{3,   5,   1'b1, 1'b0, 22,  15};
    vt[8]  = '{128, 1,   1'b1, 1'b0, 260, 128};
    vt[9]  = '{5,   3,   1'b0, 1'b0, 24,  15};
    vt[10] = '{255, 255, 1'b0, 1'b1, 0,   0};

    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_conv", conv_rst_n, 1);
    chk("post_rst_busy", busy, 0);

    load_golden();
    run_frame(4, 4, 1'b1, 2'd0, 1'b0, 24, 16);
    check_golden("golden");

    foreach (vt[i]) begin
      fill_rand(vt[i].w * vt[i].h);
      run_frame(vt[i].w, vt[i].h, vt[i].relu, 2'(i),
                vt[i].exp_err, vt[i].exp_lat, vt[i].exp_wr);
    end

    // start together with abort in IDLE must not start a frame
    @(negedge clk);
    cfg_width = 8'd4;
    cfg_height = 8'd4;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_err", err, 0);
    @(negedge clk);
    chk("abort_idle_busy2", busy, 0);

    // abort at cnt 9 of a 4x4 frame
    load_golden();
    fw = 4;
    fh = 4;
    frelu = 1'b1;
    issue_start(4, 4, 1'b1, 2'd0);
    repeat (10) @(negedge clk);
    c0 = total_writes;
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_clr", conv_rst_n, 0);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    chk("abort_idle", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_writes", int'(total_writes - c0 <= 1), 1);
    load_golden();
    run_frame(4, 4, 1'b1, 2'd0, 1'b0, 24, 16);
    check_golden("after_abort");

    // async reset at cnt 10
    load_golden();
    issue_start(4, 4, 1'b1, 2'd0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    prev_w = 0;
    @(negedge clk);
    chk("rst_mid_idle", busy, 0);
    load_golden();
    run_frame(4, 4, 1'b1, 2'd0, 1'b0, 24, 16);
    check_golden("after_reset");

    // start held high across a whole frame
    fill_rand(6);
    fw = 3;
    fh = 2;
    frelu = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    cfg_width = 8'd3;
    cfg_height = 8'd2;
    cfg_relu = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("held_busy", busy, 1);
    wait_done(cyc, clr);
    chk("held_lat", cyc, 13);
    chk("held_writes", last_writes, 6);
    @(negedge clk);
    chk("held_idle", busy, 0);
    @(negedge clk);
    chk("held_restart", busy, 1);
    start = 1'b0;
    wait_done(cyc, clr);
    chk("held_lat2", cyc, 13);
    chk("held_writes2", last_writes, 6);
    @(negedge clk);
    chk("held_dones", done_cnt - d0, 2);

    for (int i = 0; i < 3; i++) begin
      w = $urandom_range(20, 2);
      h = $urandom_range(10, 1);
      r = 1'($urandom);
      fill_rand(w * h);
      run_frame(w, h, r, 2'd0, 1'b0, w*h + w + 4, w*h);
    end

    fill_rand(16384);
    r = 1'($urandom);
    run_frame(128, 128, r, 2'd0, 1'b0, 16384 + 128 + 4, 16384);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
